data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied p1 cycles before p1 is force-granted (range 1..15).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports p0_req/p0_we  input  1 each  CPU access request; write when p0_we=1, else read.
REQ-005 SHALL have ports p0_addr, p0_wdata  input  32 each; p0_mask  input  4  sign/size mask, passed unmodified.
REQ-006 SHALL have ports p0_gnt, p0_rvalid, p0_stall  output  1 each; p0_rdata  output  32.
REQ-007 SHALL have port group p1_* identical to p0_* (no p1_stall), plus p1_lock  input  1  hold grant for atomic sequence.
REQ-008 SHALL have ports mem_addr, mem_wdata  output  32; mem_memread, mem_memwrite  output  1; mem_sign_mask  output  4; mem_rdata  input  32.

Function
REQ-009 SHALL grant at most one port per cycle; grant is combinational from current requests and registered state.
REQ-010 SHALL drive mem_* from the granted port in the same cycle: mem_memwrite=we, mem_memread=~we; with no grant, all mem_* outputs are 0.
REQ-011 SHALL keep an FSM with states OPEN and LOCKED.
REQ-012 In OPEN, priority: (a) p1 if p1_req and starve_cnt==STARVE_LIMIT; (b) p0 if p0_req; (c) p1 if p1_req.
REQ-013 In LOCKED, SHALL grant only p1 (if p1_req); p0 is denied regardless of starve_cnt.
REQ-014 OPEN->LOCKED when p1 granted with p1_lock=1; LOCKED->OPEN when p1_req=0, or p1 granted with p1_lock=0.
REQ-015 starve_cnt (4 bits): +1 when p1_req & ~p1_gnt, saturating at STARVE_LIMIT; cleared to 0 when p1_gnt or ~p1_req.
REQ-016 On a granted read, SHALL register pending-valid and port id; next cycle asserts that port's rvalid for exactly one cycle.
REQ-017 p0_rdata and p1_rdata SHALL both equal mem_rdata combinationally; only the rvalid selects the owner.
REQ-018 Reads SHALL be pipelined: a new grant is permitted in the cycle a previous read's rvalid is asserted (throughput 1 access/cycle).
REQ-019 Writes produce no rvalid; a write is complete at the clock edge ending its grant cycle.
REQ-020 p0_stall SHALL equal p0_req & ~p0_gnt, combinationally.
REQ-021 Requesters SHALL hold req/addr/wdata/mask stable until granted; arbiter samples nothing while ungranted.
REQ-022 Simultaneous p0_req and p1_req with starve_cnt<STARVE_LIMIT in OPEN: p0 granted, starve_cnt increments.
REQ-023 Addresses (including the LED register at 0x2000) SHALL pass through unmodified; no decode in this block.

Reset
REQ-024 On reset=1 at a clock edge: state=OPEN, starve_cnt=0, pending-valid=0; next cycle rvalid outputs are 0.
REQ-025 Reset asserted in the cycle after a read grant SHALL suppress that read's rvalid.
REQ-026 While reset=1, gnt outputs and mem_memread/mem_memwrite SHALL be 0.

Verification
REQ-027 p0 read addr 0x10 alone -> p0_gnt=1, mem_memread=1, mem_addr=0x10 same cycle; p0_rvalid=1 next cycle, p0_rdata=mem_rdata.
REQ-028 p0 and p1 request continuously, STARVE_LIMIT=4 -> p0 granted 4 cycles, p1 granted on 5th, starve_cnt returns to 0, p0_stall=1 that cycle.
REQ-029 p1 read with p1_lock=1, then write with p1_lock=0 while p0_req=1 -> p0 denied for both cycles, granted on third; state returns OPEN.
REQ-030 Back-to-back p0 read 0x20, p1 read 0x24 -> p0_rvalid cycle n+1, p1_rvalid cycle n+2, never both high.
REQ-031 p0 write 0x2000 data 0xA5 -> mem_memwrite=1, mem_wdata=0xA5, no rvalid in next cycle.
REQ-032 Reset asserted cycle after p1 read grant while LOCKED -> no p1_rvalid, state OPEN, starve_cnt=0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: CPU port p0 has priority, p1 gets anti-starvation
// forcing and an atomic lock; reads return rvalid one cycle after grant.
module data_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  input  logic [3:0]  p0_mask_i,
  output logic        p0_gnt_o,
  output logic        p0_rvalid_o,
  output logic        p0_stall_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic        p1_lock_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  input  logic [3:0]  p1_mask_i,
  output logic        p1_gnt_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_memread_o,
  output logic        mem_memwrite_o,
  output logic [3:0]  mem_sign_mask_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic {OPEN, LOCKED} state_e;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       pend_valid_q, pend_valid_d;
  logic       pend_port_q, pend_port_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= OPEN;
      starve_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_port_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      pend_valid_q <= pend_valid_d;
      pend_port_q  <= pend_port_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    pend_valid_d = (p0_gnt_o & ~p0_we_i) | (p1_gnt_o & ~p1_we_i);
    pend_port_d  = p1_gnt_o;
    case (state_q)
      OPEN:    if (p1_gnt_o && p1_lock_i) state_d = LOCKED;
      LOCKED:  if (!p1_req_i || (p1_gnt_o && !p1_lock_i)) state_d = OPEN;
      default: state_d = OPEN;
    endcase
    if (p1_gnt_o || !p1_req_i) begin
      starve_d = '0;
    end else if (starve_q < Limit) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Grant is purely combinational; reset forces everything idle in the same cycle.
  always_comb begin
    p0_gnt_o        = 1'b0;
    p1_gnt_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    mem_memread_o   = 1'b0;
    mem_memwrite_o  = 1'b0;
    mem_sign_mask_o = '0;
    if (!reset_i) begin
      if (state_q == LOCKED) begin
        p1_gnt_o = p1_req_i;
      end else if (p1_req_i && starve_q == Limit) begin
        p1_gnt_o = 1'b1;
      end else if (p0_req_i) begin
        p0_gnt_o = 1'b1;
      end else begin
        p1_gnt_o = p1_req_i;
      end
    end
    if (p0_gnt_o) begin
      mem_addr_o      = p0_addr_i;
      mem_wdata_o     = p0_wdata_i;
      mem_memread_o   = ~p0_we_i;
      mem_memwrite_o  = p0_we_i;
      mem_sign_mask_o = p0_mask_i;
    end else if (p1_gnt_o) begin
      mem_addr_o      = p1_addr_i;
      mem_wdata_o     = p1_wdata_i;
      mem_memread_o   = ~p1_we_i;
      mem_memwrite_o  = p1_we_i;
      mem_sign_mask_o = p1_mask_i;
    end
  end

  assign p0_stall_o  = p0_req_i & ~p0_gnt_o;
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;
  // Reset in the return cycle kills the pending rvalid.
  assign p0_rvalid_o = pend_valid_q & ~pend_port_q & ~reset_i;
  assign p1_rvalid_o = pend_valid_q & pend_port_q & ~reset_i;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with STARVE_LIMIT=4;
// expected values are hand-derived per cycle.
module tb_data_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        p0_req_i, p0_we_i;
  logic [31:0] p0_addr_i, p0_wdata_i;
  logic [3:0]  p0_mask_i;
  logic        p0_gnt_o, p0_rvalid_o, p0_stall_o;
  logic [31:0] p0_rdata_o;
  logic        p1_req_i, p1_we_i, p1_lock_i;
  logic [31:0] p1_addr_i, p1_wdata_i;
  logic [3:0]  p1_mask_i;
  logic        p1_gnt_o, p1_rvalid_o;
  logic [31:0] p1_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_memread_o, mem_memwrite_o;
  logic [3:0]  mem_sign_mask_o;
  logic [31:0] mem_rdata_i;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk_i = ~clk_i;

  data_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
    .p0_wdata_i(p0_wdata_i), .p0_mask_i(p0_mask_i),
    .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_stall_o(p0_stall_o),
    .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_lock_i(p1_lock_i),
    .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i), .p1_mask_i(p1_mask_i),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_memread_o(mem_memread_o), .mem_memwrite_o(mem_memwrite_o),
    .mem_sign_mask_o(mem_sign_mask_o), .mem_rdata_i(mem_rdata_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 3 units later.
  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic w0, input logic [31:0] a0,
                               input logic r1, input logic w1, input logic l1,
                               input logic [31:0] a1, input logic [31:0] rdata);
    @(posedge clk_i);
    #1;
    reset_i     = rst;
    p0_req_i    = r0;
    p0_we_i     = w0;
    p0_addr_i   = a0;
    p0_wdata_i  = a0 ^ 32'h5555_0000;
    p0_mask_i   = 4'h3;
    p1_req_i    = r1;
    p1_we_i     = w1;
    p1_lock_i   = l1;
    p1_addr_i   = a1;
    p1_wdata_i  = a1 ^ 32'hAAAA_0000;
    p1_mask_i   = 4'hC;
    mem_rdata_i = rdata;
    #3;
  endtask

  task automatic checkGrants(input string tag, input logic g0, input logic g1);
    checkOutput({tag, ".p0_gnt"}, 32'(p0_gnt_o), 32'(g0));
    checkOutput({tag, ".p1_gnt"}, 32'(p1_gnt_o), 32'(g1));
  endtask

  task automatic checkValids(input string tag, input logic v0, input logic v1);
    checkOutput({tag, ".p0_rvalid"}, 32'(p0_rvalid_o), 32'(v0));
    checkOutput({tag, ".p1_rvalid"}, 32'(p1_rvalid_o), 32'(v1));
  endtask

  initial begin
    reset_i = 1'b1;
    p0_req_i = 0; p0_we_i = 0; p0_addr_i = '0; p0_wdata_i = '0; p0_mask_i = '0;
    p1_req_i = 0; p1_we_i = 0; p1_lock_i = 0; p1_addr_i = '0; p1_wdata_i = '0;
    p1_mask_i = '0; mem_rdata_i = '0;

    // Reset held with a pending request: nothing may be granted
    applyStimulus(1, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    checkGrants("rst", 0, 0);
    checkOutput("rst.memread", 32'(mem_memread_o), 0);
    checkOutput("rst.memwrite", 32'(mem_memwrite_o), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkValids("postrst", 0, 0);
    checkOutput("postrst.mem_addr", mem_addr_o, 0);

    // Single p0 read of 0x10
    applyStimulus(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    checkGrants("rd0", 1, 0);
    checkOutput("rd0.memread", 32'(mem_memread_o), 1);
    checkOutput("rd0.memwrite", 32'(mem_memwrite_o), 0);
    checkOutput("rd0.mem_addr", mem_addr_o, 32'h10);
    checkOutput("rd0.mask", 32'(mem_sign_mask_o), 32'h3);
    checkOutput("rd0.stall", 32'(p0_stall_o), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_0010);
    checkValids("rd0.ret", 1, 0);
    checkOutput("rd0.p0_rdata", p0_rdata_o, 32'hCAFE_0010);
    checkOutput("rd0.p1_rdata", p1_rdata_o, 32'hCAFE_0010);
    checkOutput("idle.memread", 32'(mem_memread_o), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkValids("rd0.once", 0, 0);

    // p0 write to the LED register: wdata = 0x2000 ^ 0x55550000
    applyStimulus(0, 1, 1, 32'h2000, 0, 0, 0, 0, 0);
    checkOutput("wr.memwrite", 32'(mem_memwrite_o), 1);
    checkOutput("wr.memread", 32'(mem_memread_o), 0);
    checkOutput("wr.addr", mem_addr_o, 32'h2000);
    checkOutput("wr.wdata", mem_wdata_o, 32'h5555_2000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkValids("wr.norvalid", 0, 0);

    // Back-to-back reads from different ports
    applyStimulus(0, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    checkGrants("b2b.n", 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h24, 32'h1111_0020);
    checkGrants("b2b.n1", 0, 1);
    checkOutput("b2b.n1.addr", mem_addr_o, 32'h24);
    checkValids("b2b.n1", 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h2222_0024);
    checkValids("b2b.n2", 0, 1);
    checkOutput("b2b.p1_rdata", p1_rdata_o, 32'h2222_0024);

    // Continuous contention: p0 wins four times, p1 forced on the fifth
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 32'h100, 1, 1, 0, 32'h200, 0);
      checkGrants($sformatf("starve%0d", i), (i != 4), (i == 4));
      checkOutput($sformatf("starve%0d.stall", i), 32'(p0_stall_o), 32'(i == 4));
      checkOutput($sformatf("starve%0d.addr", i), mem_addr_o,
                  (i == 4) ? 32'h200 : 32'h100);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Starved p1 takes a locked read, then releases with a write
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 32'h300, 1, 0, 1, 32'h304, 0);
      checkGrants($sformatf("lock%0d", i), (i != 4), (i == 4));
    end
    applyStimulus(0, 1, 0, 32'h300, 1, 1, 0, 32'h308, 0);
    checkGrants("lock.rel", 0, 1);
    checkOutput("lock.rel.stall", 32'(p0_stall_o), 1);
    checkOutput("lock.rel.memwrite", 32'(mem_memwrite_o), 1);
    checkValids("lock.rel", 0, 1);
    applyStimulus(0, 1, 0, 32'h300, 0, 0, 0, 0, 0);
    checkGrants("lock.open", 1, 0);
    checkValids("lock.open", 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lock dropped by withdrawing p1_req: p0 still denied that cycle
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h400, 0);
    checkGrants("drop.lock", 0, 1);
    applyStimulus(0, 1, 0, 32'h404, 0, 0, 0, 0, 0);
    checkGrants("drop.locked", 0, 0);
    checkOutput("drop.stall", 32'(p0_stall_o), 1);
    applyStimulus(0, 1, 0, 32'h404, 0, 0, 0, 0, 0);
    checkGrants("drop.open", 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the return cycle of a locked p1 read
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h500, 0);
    checkGrants("rstlk.gnt", 0, 1);
    applyStimulus(1, 1, 0, 32'h504, 1, 0, 1, 32'h500, 32'h7777_0500);
    checkValids("rstlk.kill", 0, 0);
    checkGrants("rstlk.held", 0, 0);
    checkOutput("rstlk.memread", 32'(mem_memread_o), 0);
    applyStimulus(0, 1, 0, 32'h504, 1, 0, 1, 32'h500, 0);
    checkGrants("rstlk.open", 1, 0);
    checkValids("rstlk.after", 0, 0);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(0, 1, 0, 32'h504, 1, 0, 0, 32'h500, 0);
      checkGrants($sformatf("rstlk.cnt%0d", i), (i != 4), (i == 4));
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
